// File: rtl/slink_tx_block_sched.sv
// Sideband link transmit block scheduler.
// Cuts the upstream word stream into 128-bit blocks for the gearbox, attaches
// the sync header on the first word of each block, and inserts one slip cycle
// per gearbox period so the extra header bits can drain.
module slink_tx_block_sched #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  encode_mode,
  input  logic [DATA_WIDTH-1:0] link_data,
  input  logic                  link_valid,
  input  logic                  link_os,
  output logic                  link_ready,
  output logic [DATA_WIDTH-1:0] gb_data,
  output logic [3:0]            gb_syncheader,
  output logic                  gb_startblock,
  output logic                  gb_datavalid,
  output logic                  gb_enable,
  output logic                  gb_encode_mode,
  output logic                  busy,
  output logic                  underrun
);

  localparam int unsigned WPB = 128 / DATA_WIDTH;
  localparam int unsigned WW  = $clog2(WPB);
  localparam int unsigned BW  = $clog2(DATA_WIDTH / 2);

  localparam logic [WW-1:0] W_LAST   = WW'(WPB - 1);
  localparam logic [BW-1:0] B_LAST_0 = BW'(DATA_WIDTH / 2 - 1);
  localparam logic [BW-1:0] B_LAST_1 = BW'(DATA_WIDTH / 4 - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    SLIP   = 2'd2
  } state_t;

  state_t        state;
  logic [WW-1:0] wcnt;
  logic [BW-1:0] bcnt;
  logic          mode_q;
  logic          stop_pending;
  logic          stop_req;
  logic [BW-1:0] b_last;
  logic          os_eff;

  assign b_last         = mode_q ? B_LAST_1 : B_LAST_0;
  assign gb_encode_mode = mode_q;
  assign busy           = (state != IDLE);

  // Block/period sequencing; a stop request is held in stop_req until the
  // current block ends, then promoted to stop_pending so the block in flight
  // still completes with real data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      bcnt         <= '0;
      mode_q       <= 1'b0;
      stop_pending <= 1'b0;
      stop_req     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            mode_q       <= encode_mode;
            wcnt         <= '0;
            bcnt         <= '0;
            stop_pending <= 1'b0;
            stop_req     <= 1'b0;
            state        <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!enable) stop_req <= 1'b1;
          if (wcnt == W_LAST) begin
            wcnt <= '0;
            if (!enable || stop_req) stop_pending <= 1'b1;
            if (bcnt == b_last) begin
              bcnt  <= '0;
              state <= SLIP;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        SLIP: begin
          if (stop_pending) begin
            stop_pending <= 1'b0;
            stop_req     <= 1'b0;
            state        <= IDLE;
          end else begin
            if (!enable) stop_pending <= 1'b1;
            state <= ACTIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gearbox-side outputs, zero-latency from the link inputs.
  always_comb begin
    link_ready    = 1'b0;
    gb_data       = '0;
    gb_syncheader = '0;
    gb_startblock = 1'b0;
    gb_datavalid  = 1'b0;
    gb_enable     = 1'b0;
    underrun      = 1'b0;
    os_eff        = link_os && link_valid && !stop_pending;
    case (state)
      ACTIVE: begin
        gb_enable     = 1'b1;
        gb_datavalid  = 1'b1;
        gb_startblock = (wcnt == '0);
        if (!stop_pending) begin
          link_ready = 1'b1;
          if (link_valid) gb_data = link_data;
          else if (wcnt != '0) underrun = 1'b1;
        end
        if (wcnt == '0) begin
          if (mode_q) gb_syncheader = os_eff ? 4'b1100 : 4'b0011;
          else        gb_syncheader = {2'b00, os_eff ? 2'b01 : 2'b10};
        end
      end
      SLIP: gb_enable = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slink_tx_block_sched.sv
// Directed bench for slink_tx_block_sched at 16, 8 and 32-bit word widths.
module tb_slink_tx_block_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        encode_mode = 1'b0;
  logic [15:0] link_data = '0;
  logic        link_valid = 1'b0;
  logic        link_os = 1'b0;
  logic        link_ready, gb_startblock, gb_datavalid, gb_enable, gb_encode_mode, busy, underrun;
  logic [15:0] gb_data;
  logic [3:0]  gb_syncheader;

  logic [7:0]  d8 = '0;
  logic [7:0]  g8;
  logic [3:0]  h8;
  logic        r8, s8, v8, e8, m8, b8, u8;
  logic [31:0] d32 = '0;
  logic [31:0] g32;
  logic [3:0]  h32;
  logic        r32, s32, v32, e32, m32, b32, u32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  slink_tx_block_sched #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .encode_mode(encode_mode),
    .link_data(link_data), .link_valid(link_valid), .link_os(link_os),
    .link_ready(link_ready), .gb_data(gb_data), .gb_syncheader(gb_syncheader),
    .gb_startblock(gb_startblock), .gb_datavalid(gb_datavalid), .gb_enable(gb_enable),
    .gb_encode_mode(gb_encode_mode), .busy(busy), .underrun(underrun));

  slink_tx_block_sched #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .encode_mode(1'b0),
    .link_data(d8), .link_valid(1'b1), .link_os(1'b0),
    .link_ready(r8), .gb_data(g8), .gb_syncheader(h8),
    .gb_startblock(s8), .gb_datavalid(v8), .gb_enable(e8),
    .gb_encode_mode(m8), .busy(b8), .underrun(u8));

  slink_tx_block_sched #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .enable(enable), .encode_mode(1'b0),
    .link_data(d32), .link_valid(1'b1), .link_os(1'b0),
    .link_ready(r32), .gb_data(g32), .gb_syncheader(h32),
    .gb_startblock(s32), .gb_datavalid(v32), .gb_enable(e32),
    .gb_encode_mode(m32), .busy(b32), .underrun(u32));

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},   gb_enable, 1'b0);
    check({tag, "_dv"},   gb_datavalid, 1'b0);
    check({tag, "_sb"},   gb_startblock, 1'b0);
    check({tag, "_rdy"},  link_ready, 1'b0);
    check({tag, "_data"}, gb_data, 16'h0);
    check({tag, "_hdr"},  gb_syncheader, 4'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_mode"}, gb_encode_mode, 1'b0);
    check({tag, "_urun"}, underrun, 1'b0);
  endtask

  task automatic reset_dut();
    reset = 1'b1; enable = 1'b0; encode_mode = 1'b0;
    link_valid = 1'b0; link_os = 1'b0; link_data = '0;
    @(negedge clk);
    reset = 1'b0;
    #1 check_all_zero("rst");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [129:0] obs, expb;
    logic [15:0]  pat, xdata;
    logic [3:0]   xhdr;
    logic         slip, drain, start, rdy, vld, os, xur;
    int           p, w;

    // ---- W16 mode 0: two periods, stop mid period 2, encode_mode toggled ----
    reset_dut();
    enable = 1'b1;
    #1 check("a_idle_busy", busy, 1'b0);
    @(negedge clk);
    obs = '0; expb = '0;
    for (int k = 0; k <= 131; k++) begin
      pat = 16'h1000 + 16'(k);
      link_data   = pat;
      link_valid  = 1'b1;
      drain       = (k >= 89 && k < 129);
      link_os     = drain;
      enable      = !(k >= 86 && k < 100);
      encode_mode = (k >= 10 && k <= 20);
      #1;
      if (k == 130) begin
        check("a_stop_busy", busy, 1'b0);
        check("a_stop_gben", gb_enable, 1'b0);
        check("a_stop_rdy",  link_ready, 1'b0);
      end else if (k == 131) begin
        check("a_restart_busy", busy, 1'b1);
      end else begin
        slip  = (k == 64 || k == 129);
        p     = (k < 65) ? k : k - 65;
        w     = p % 8;
        rdy   = !slip && !drain;
        start = !slip && (w == 0);
        xdata = rdy ? pat : 16'h0;
        xhdr  = start ? 4'b0010 : 4'b0000;
        check($sformatf("a_gben%0d", k), gb_enable, 1'b1);
        check($sformatf("a_dv%0d", k), gb_datavalid, !slip);
        check($sformatf("a_sb%0d", k), gb_startblock, start);
        check($sformatf("a_rdy%0d", k), link_ready, rdy);
        check($sformatf("a_data%0d", k), gb_data, xdata);
        check($sformatf("a_hdr%0d", k), gb_syncheader, xhdr);
        check($sformatf("a_urun%0d", k), underrun, 1'b0);
        check($sformatf("a_mode%0d", k), gb_encode_mode, 1'b0);
        if (k < 64) begin
          if (start) begin
            obs  = {112'b0, gb_syncheader[1:0], gb_data};
            expb = {112'b0, 2'b10, pat};
          end else begin
            obs  = {obs[113:0], gb_data};
            expb = {expb[113:0], pat};
          end
          if (w == 7) check($sformatf("a_block%0d", k / 8), obs, expb);
        end
      end
      @(negedge clk);
    end

    // ---- W16 mode 1: ordered-set headers, idle start, underrun, reset mid-block ----
    reset_dut();
    encode_mode = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    encode_mode = 1'b0;
    for (int k = 0; k <= 36; k++) begin
      pat        = 16'h2000 + 16'(k);
      vld        = !(k == 16 || k == 19);
      os         = (k == 0 || k == 3 || k == 16);
      link_data  = pat;
      link_valid = vld;
      link_os    = os;
      #1;
      slip  = (k == 32);
      p     = (k < 33) ? k : k - 33;
      w     = p % 8;
      rdy   = !slip;
      start = !slip && (w == 0);
      xdata = (rdy && vld) ? pat : 16'h0;
      xur   = rdy && !vld && (w != 0);
      xhdr  = !start ? 4'b0000 : ((os && vld) ? 4'b1100 : 4'b0011);
      check($sformatf("b_dv%0d", k), gb_datavalid, !slip);
      check($sformatf("b_sb%0d", k), gb_startblock, start);
      check($sformatf("b_rdy%0d", k), link_ready, rdy);
      check($sformatf("b_data%0d", k), gb_data, xdata);
      check($sformatf("b_hdr%0d", k), gb_syncheader, xhdr);
      check($sformatf("b_urun%0d", k), underrun, xur);
      check($sformatf("b_mode%0d", k), gb_encode_mode, 1'b1);
      @(negedge clk);
    end
    link_valid = 1'b1;
    reset = 1'b1;
    #1 check_all_zero("b_midrst");
    @(negedge clk);
    reset = 1'b0;
    #1 check("b_post_rst_busy", busy, 1'b0);
    @(negedge clk);
    #1 check("b_post_rst_run", busy, 1'b1);

    // ---- W8 and W32 mode 0: period 65, bit-exact block reconstruction ----
    reset_dut();
    enable = 1'b1;
    @(negedge clk);
    begin
      logic [129:0] ob8, ex8, ob32, ex32;
      logic [7:0]   p8;
      logic [31:0]  p32;
      logic         st8, st32;
      int           w8, w32;
      ob8 = '0; ex8 = '0; ob32 = '0; ex32 = '0;
      for (int k = 0; k <= 65; k++) begin
        p8  = 8'h5A ^ 8'(k);
        p32 = {16'hC0DE, 16'(k)};
        d8  = p8;
        d32 = p32;
        #1;
        slip = (k == 64);
        p    = (k < 65) ? k : 0;
        w8   = p % 16;
        w32  = p % 4;
        st8  = !slip && (w8 == 0);
        st32 = !slip && (w32 == 0);
        check($sformatf("c8_dv%0d", k), v8, !slip);
        check($sformatf("c8_sb%0d", k), s8, st8);
        check($sformatf("c8_rdy%0d", k), r8, !slip);
        check($sformatf("c8_data%0d", k), g8, slip ? 8'h0 : p8);
        check($sformatf("c8_hdr%0d", k), h8, st8 ? 4'b0010 : 4'b0000);
        check($sformatf("c32_dv%0d", k), v32, !slip);
        check($sformatf("c32_sb%0d", k), s32, st32);
        check($sformatf("c32_rdy%0d", k), r32, !slip);
        check($sformatf("c32_data%0d", k), g32, slip ? 32'h0 : p32);
        check($sformatf("c32_hdr%0d", k), h32, st32 ? 4'b0010 : 4'b0000);
        if (k == 0) begin
          check("c_en", {e8, e32, b8, b32}, 4'b1111);
          check("c_mode_urun", {m8, m32, u8, u32}, 4'b0000);
        end
        if (k < 64) begin
          if (st8) begin
            ob8 = {120'b0, h8[1:0], g8};
            ex8 = {120'b0, 2'b10, p8};
          end else begin
            ob8 = {ob8[121:0], g8};
            ex8 = {ex8[121:0], p8};
          end
          if (w8 == 15) check($sformatf("c8_block%0d", k / 16), ob8, ex8);
          if (st32) begin
            ob32 = {96'b0, h32[1:0], g32};
            ex32 = {96'b0, 2'b10, p32};
          end else begin
            ob32 = {ob32[97:0], g32};
            ex32 = {ex32[97:0], p32};
          end
          if (w32 == 3) check($sformatf("c32_block%0d", k / 4), ob32, ex32);
        end
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slink_tx_block_sched.md
SLINK_TX_BLOCK_SCHED -- requirements
Module: slink_tx_block_sched

Interface
REQ-001 Parameter: DATA_WIDTH, 16, word width; legal values 8, 16, 32; WPB = 128/DATA_WIDTH words per block.
REQ-002 One clock, clk; reset is asynchronous and active-high, named reset.
REQ-003 clk  input  1  block clock, rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 enable  input  1  run request.
REQ-006 encode_mode  input  1  0 = 128b130b, 1 = 128b132b; sampled only in IDLE.
REQ-007 link_data  input  DATA_WIDTH  upstream payload word.
REQ-008 link_valid  input  1  link_data valid.
REQ-009 link_os  input  1  block is ordered-set; meaningful only on the first word of a block.
REQ-010 link_ready  output  1  word accepted when link_valid && link_ready.
REQ-011 gb_data  output  DATA_WIDTH  word to gearbox.
REQ-012 gb_syncheader  output  4  sync header to gearbox.
REQ-013 gb_startblock  output  1  first word of block.
REQ-014 gb_datavalid  output  1  gearbox advance.
REQ-015 gb_enable  output  1  gearbox enable.
REQ-016 gb_encode_mode  output  1  latched mode (mode_q).
REQ-017 busy  output  1  state != IDLE.
REQ-018 underrun  output  1  one-cycle pulse: mid-block word missing.

Function
REQ-019 HB = 2 (mode_q = 0) or 4 (mode_q = 1); BPS = DATA_WIDTH/HB blocks per slip period.
REQ-020 States: IDLE, ACTIVE, SLIP. Counters: wcnt 0..WPB-1 (word in block), bcnt 0..BPS-1 (block in period).
REQ-021 IDLE: gb_enable = 0, link_ready = 0, gb_datavalid = 0, gb_startblock = 0, gb_data = 0; when enable = 1, mode_q <= encode_mode, wcnt <= 0, bcnt <= 0, next state ACTIVE.
REQ-022 ACTIVE: gb_enable = 1, gb_datavalid = 1, gb_startblock = (wcnt == 0), wcnt increments every cycle and wraps WPB-1 -> 0.
REQ-023 ACTIVE with stop_pending = 0: link_ready = 1; gb_data = link_data if link_valid, else all zeros.
REQ-024 link_valid = 0 at wcnt == 0: idle block (zero payload, data header), no underrun; link_valid = 0 at wcnt != 0: zero word substituted, underrun pulses that cycle.
REQ-025 gb_syncheader is combinational on gb_startblock cycles: mode 0 -> {2'b00, link_os ? 2'b01 : 2'b10}; mode 1 -> link_os ? 4'b1100 : 4'b0011; link_os is treated as 0 when link_valid = 0 or stop_pending = 1; value is 0 on non-start cycles.
REQ-026 At wcnt == WPB-1, bcnt increments; if bcnt == BPS-1, bcnt <= 0 and next state SLIP.
REQ-027 SLIP lasts exactly one cycle: gb_enable = 1, gb_datavalid = 0, gb_startblock = 0, link_ready = 0, gb_data = 0; next state ACTIVE, or IDLE if stop_pending.
REQ-028 Slip period = BPS*WPB + 1 cycles (65 for mode 0, 33 for mode 1 at every DATA_WIDTH); output is gap-free.
REQ-029 enable = 0 while ACTIVE sets stop_pending; it takes effect at the next block boundary: all later blocks are idle blocks with link_ready = 0 until the SLIP cycle, then IDLE; gb_enable stays 1 until IDLE.
REQ-030 enable re-asserted before IDLE does not clear stop_pending; encode_mode changes outside IDLE are ignored.
REQ-031 All gb_* and link_ready outputs are combinational from registered state and link inputs; link -> gb latency is 0 cycles.

Reset
REQ-032 On reset: state = IDLE, wcnt = 0, bcnt = 0, mode_q = 0, stop_pending = 0; all outputs 0.
REQ-033 Reset mid-period aborts immediately with no drain; the first cycle after release is IDLE.

Verification
REQ-034 W=16, mode 0, enable held, link_valid = 1: gb_startblock every 8 cycles; SLIP (link_ready = 0) after 64 accepted words; period 65 cycles; concatenated gearbox output equals 8 x 130-bit blocks with header 10.
REQ-035 W=16, mode 1: SLIP after 32 words, period 33 cycles; headers 0011 (data) and 1100 (link_os = 1 on the first word).
REQ-036 link_valid = 0 at wcnt = 3: gb_data = 0 and underrun = 1 for that cycle; link_valid = 0 at wcnt = 0: no underrun, idle block with data header.
REQ-037 enable dropped at bcnt = 2, wcnt = 5: current block completes with data, later blocks are idle with link_ready = 0, IDLE follows SLIP, gb_enable falls in the same cycle.
REQ-038 encode_mode toggled while ACTIVE: gb_encode_mode unchanged; reset asserted at wcnt = 4: all outputs 0 asynchronously, then IDLE.
REQ-039 W=8 and W=32, mode 0: BPS = 4 and 16 respectively, period 65 cycles; bit-exact block reconstruction.
